ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL take parameter MAX_BURST, default 8, as the maximum consecutive grants requester 1 may hold while locked (range 1..255).
REQ-002 SHALL take address width from `RAM_ADDRESS_BITWIDTH` (AW) in define.sv.
REQ-003 SHALL have port clk, input, 1 bit, the single clock for all state.
REQ-004 SHALL have port reset_n, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-005 SHALL have ports m0_req/m0_wren, input, 1 bit each: CPU MEM-stage access request and write flag.
REQ-006 SHALL have ports m0_addr, input, AW bits, and m0_write_data, input, 32 bits.
REQ-007 SHALL have ports m0_gnt, output, 1 bit; m0_rvalid, output, 1 bit; m0_rdata, output, 32 bits.
REQ-008 SHALL have ports m1_req, m1_wren, m1_lock, m1_addr, m1_write_data, m1_gnt, m1_rvalid and m1_rdata, with the same widths and meanings as the m0 set, for the UART loader; m1_lock, input, 1 bit, requests burst ownership.
REQ-009 SHALL have ports ram_address, output, AW bits; ram_write_data, output, 32 bits; ram_wren, output, 1 bit; ram_data, input, 32 bits. ram_data is the RAM read data, valid one cycle after the address.

Function
REQ-010 SHALL compute mX_gnt combinationally in the same cycle as mX_req, with at most one grant per cycle.
REQ-011 SHALL drive ram_address, ram_write_data and ram_wren from the granted requester; with no grant, it SHALL drive ram_wren=0 and ram_address=0.
REQ-012 SHALL, for a granted read, assert rvalid of that requester exactly one cycle later, with rdata=ram_data in that cycle.
REQ-013 SHALL never assert rvalid for a granted write, and SHALL hold both rdata outputs at 0 when rvalid is low.
REQ-014 SHALL implement states RR and BURST, with a 1-bit priority pointer prio (0=m0 favoured) and an 8-bit burst counter bcnt.
REQ-015 In RR, SHALL grant the sole requester if only one requests; if both request, SHALL grant the one selected by prio.
REQ-016 In RR, SHALL set prio to the non-granted requester after every grant; with no grant, prio SHALL be unchanged.
REQ-017 SHALL move RR->BURST when m1 is granted with m1_lock=1, setting bcnt=1.
REQ-018 In BURST, SHALL grant m1 whenever m1_req=1, ignoring prio, and SHALL increment bcnt on each m1 grant.
REQ-019 In BURST with m1_req=0, SHALL grant m0 if m0_req=1 (hole fill), remain in BURST and leave bcnt unchanged.
REQ-020 SHALL move BURST->RR when m1_lock=0 is sampled; that cycle SHALL be arbitrated as RR with prio=0.
REQ-021 SHALL move BURST->RR with prio=0 when a grant makes bcnt reach MAX_BURST. The next cycle SHALL favour m0, so m1 cannot re-enter BURST while m0 is waiting.
REQ-022 SHALL, when MAX_BURST=1, behave exactly as RR, passing through BURST for zero grants.
REQ-023 SHALL give the granted requester's write sole ownership when both requesters write the same address in the same cycle; the loser sees no side effect.
REQ-024 SHALL saturate bcnt; it SHALL never wrap.

Reset
REQ-025 SHALL, on reset_n=0 at a clk edge, set state=RR, prio=0, bcnt=0, the read-pending flags=0, m0_rvalid=m1_rvalid=0 and rdata=0.
REQ-026 SHALL hold m0_gnt=m1_gnt=0 and ram_wren=0 while reset_n=0.
REQ-027 SHALL drop a read granted in the cycle before reset asserts: no rvalid after reset.

Structure
REQ-028 SHALL declare the state enum (RR, BURST) and requester-index constants in the shared package with the other pipeline typedefs; AW SHALL stay in define.sv.
REQ-029 SHALL instantiate one sub-module, rr_pick2, as a pure combinational two-way pick of (req0, req1, prio) -> (gnt0, gnt1); all sequential state SHALL live in ram_arbiter.

Verification
REQ-030 Both requesters read continuously, no lock -> grants alternate m0,m1,m0,...; each rvalid arrives 1 cycle after its grant and rdata matches the preloaded RAM value.
REQ-031 MAX_BURST=4, m1_lock=1, both requesting -> m1 gets 4 consecutive grants, then m0 is granted; m1 is granted next under RR.
REQ-032 In BURST, m1_req low for 1 cycle while m0_req=1 -> m0 granted that cycle, state remains BURST, bcnt unchanged (e.g. stays 2).
REQ-033 m0 writes 0xDEADBEEF and m1 writes 0x12345678 to address 0x10 in the same cycle with prio=0 -> RAM[0x10]=0xDEADBEEF; m1 retries next cycle and RAM[0x10]=0x12345678.
REQ-034 m0 read granted, then reset_n=0 in the next cycle -> m0_rvalid stays 0; after release, state=RR, prio=0 and the first contended grant goes to m0.
REQ-035 m1_lock dropped after 2 of MAX_BURST=8 beats -> RR resumes with prio=0, and m0 is granted if both are requesting.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-master RAM arbiter.
`include "define.sv"

package ram_arbiter_pkg;
    localparam int AW     = `RAM_ADDRESS_BITWIDTH;
    localparam int DW     = 32;
    localparam int REQ_M0 = 0;
    localparam int REQ_M1 = 1;

    typedef enum logic {ST_RR, ST_BURST} arb_state_e;
    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] data_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// Requester (CPU m0, UART loader m1) and RAM-side signals of the arbiter.
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    logic  m0_req, m0_wren, m0_gnt, m0_rvalid;
    addr_t m0_addr;
    data_t m0_write_data, m0_rdata;

    logic  m1_req, m1_wren, m1_lock, m1_gnt, m1_rvalid;
    addr_t m1_addr;
    data_t m1_write_data, m1_rdata;

    addr_t ram_address;
    data_t ram_write_data, ram_data;
    logic  ram_wren;

    modport slave (
        input  m0_req, m0_wren, m0_addr, m0_write_data,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_wren, m1_lock, m1_addr, m1_write_data,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_address, ram_write_data, ram_wren,
        input  ram_data
    );

    modport master (
        output m0_req, m0_wren, m0_addr, m0_write_data,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_wren, m1_lock, m1_addr, m1_write_data,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_address, ram_write_data, ram_wren,
        output ram_data
    );
endinterface

// File: rtl/define.sv
// Global build-time sizing shared by the RAM path.
`ifndef RAM_ARBITER_DEFINE_SV
`define RAM_ARBITER_DEFINE_SV
`define RAM_ADDRESS_BITWIDTH 8
`endif

// File: rtl/ram_arbiter_rr_pick2.sv
// Pure combinational two-way pick; prio=0 favours req0 on contention.
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic prio_i,
    output logic gnt0_o,
    output logic gnt1_o
);
    assign gnt0_o = req0_i & (~req1_i | ~prio_i);
    assign gnt1_o = req1_i & (~req0_i |  prio_i);
endmodule

// File: rtl/ram_arbiter.sv
// Two-master single-port RAM arbiter: round robin with a bounded m1 burst lock.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    ram_arbiter_if.slave  bus
);
    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    arb_state_e state_q, state_d;
    logic       prio_q, prio_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic [1:0] pend_q, pend_d;
    logic [1:0] pick, gnt;
    logic       burst_hold, pick_prio;

    // Dropping the lock out of BURST arbitrates that very cycle as RR favouring m0.
    assign burst_hold = (state_q == ST_BURST) && bus.m1_lock;
    assign pick_prio  = (state_q == ST_BURST) ? 1'b0 : prio_q;

    rr_pick2 u_pick (
        .req0_i (bus.m0_req),
        .req1_i (bus.m1_req),
        .prio_i (pick_prio),
        .gnt0_o (pick[REQ_M0]),
        .gnt1_o (pick[REQ_M1])
    );

    always_comb begin
        gnt     = 2'b00;
        state_d = state_q;
        prio_d  = pick_prio;
        bcnt_d  = bcnt_q;
        if (reset_n) begin
            if (burst_hold) begin
                gnt[REQ_M1] = bus.m1_req;
                gnt[REQ_M0] = !bus.m1_req && bus.m0_req;
            end else begin
                gnt = pick;
            end
        end
        if (burst_hold) begin
            if (gnt[REQ_M1]) begin
                bcnt_d = (bcnt_q == 8'hFF) ? bcnt_q : bcnt_q + 8'd1;
                if (bcnt_d >= MAX_B) begin
                    state_d = ST_RR;
                    prio_d  = 1'b0;
                end
            end
        end else begin
            state_d = ST_RR;
            if (gnt[REQ_M0])      prio_d = 1'b1;
            else if (gnt[REQ_M1]) prio_d = 1'b0;
            // A one-beat burst limit expires on entry, so stay in RR.
            if (gnt[REQ_M1] && bus.m1_lock) begin
                bcnt_d = 8'd1;
                if (MAX_B > 8'd1) state_d = ST_BURST;
            end
        end
        pend_d = gnt & {~bus.m1_wren, ~bus.m0_wren};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_RR;
            prio_q  <= 1'b0;
            bcnt_q  <= 8'd0;
            pend_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            bcnt_q  <= bcnt_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.m0_gnt         = gnt[REQ_M0];
    assign bus.m1_gnt         = gnt[REQ_M1];
    assign bus.ram_address    = gnt[REQ_M1] ? bus.m1_addr :
                                gnt[REQ_M0] ? bus.m0_addr : '0;
    assign bus.ram_write_data = gnt[REQ_M1] ? bus.m1_write_data :
                                gnt[REQ_M0] ? bus.m0_write_data : '0;
    assign bus.ram_wren       = (gnt[REQ_M1] & bus.m1_wren) | (gnt[REQ_M0] & bus.m0_wren);

    // A read still pending when reset asserts is squashed.
    assign bus.m0_rvalid = pend_q[REQ_M0] & reset_n;
    assign bus.m1_rvalid = pend_q[REQ_M1] & reset_n;
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.ram_data : '0;
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.ram_data : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter (MAX_BURST=4) with a behavioural 1-cycle RAM.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    typedef struct {
        int    cyc;
        data_t data;
    } rexp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc_n = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [1:0] gq[$];
    rexp_t      r0q[$];
    rexp_t      r1q[$];
    data_t      mem [0:(1<<AW)-1];

    ram_arbiter_if bus ();

    ram_arbiter #(.MAX_BURST(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_write_data;
        bus.ram_data <= mem[bus.ram_address];
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc_n, act, exp);
        end
    endfunction

    // Monitor: compares grants, idle bus and read returns against queued expectations.
    always @(negedge clk) begin
        logic [1:0] eg;
        logic e0, e1;
        if (gq.size() > 0) begin
            eg = gq.pop_front();
            chk("grant", {30'd0, bus.m0_gnt, bus.m1_gnt}, {30'd0, eg});
        end
        if (!bus.m0_gnt && !bus.m1_gnt)
            chk("idle_bus", {23'd0, bus.ram_wren, bus.ram_address}, 32'd0);
        e0 = (r0q.size() > 0) && (r0q[0].cyc == cyc_n);
        e1 = (r1q.size() > 0) && (r1q[0].cyc == cyc_n);
        chk("m0_rvalid", {31'd0, bus.m0_rvalid}, {31'd0, e0});
        chk("m1_rvalid", {31'd0, bus.m1_rvalid}, {31'd0, e1});
        if (e0) begin
            chk("m0_rdata", bus.m0_rdata, r0q[0].data);
            void'(r0q.pop_front());
        end else chk("m0_rdata_idle", bus.m0_rdata, 32'd0);
        if (e1) begin
            chk("m1_rdata", bus.m1_rdata, r1q[0].data);
            void'(r1q.pop_front());
        end else chk("m1_rdata_idle", bus.m1_rdata, 32'd0);
    end

    // eg = {m0_gnt, m1_gnt}; ed = read data expected one cycle later from the granted master.
    task automatic step(input logic rn,
                        input logic r0, input logic w0, input addr_t a0, input data_t d0,
                        input logic r1, input logic w1, input logic l1, input addr_t a1, input data_t d1,
                        input logic [1:0] eg, input data_t ed, input bit keep_rd = 1'b1);
        @(posedge clk);
        #1;
        reset_n = rn;
        bus.m0_req = r0; bus.m0_wren = w0; bus.m0_addr = a0; bus.m0_write_data = d0;
        bus.m1_req = r1; bus.m1_wren = w1; bus.m1_lock = l1; bus.m1_addr = a1; bus.m1_write_data = d1;
        gq.push_back(eg);
        if (eg[1] && !w0 && keep_rd) r0q.push_back('{cyc_n + 1, ed});
        if (eg[0] && !w1 && keep_rd) r1q.push_back('{cyc_n + 1, ed});
    endtask

    task automatic bothrd(input logic lock, input logic [1:0] eg);
        step(1'b1, 1'b1, 1'b0, 8'h04, 32'd0, 1'b1, 1'b0, lock, 8'h05, 32'd0,
             eg, eg[1] ? 32'hA500_0004 : 32'hA500_0005);
    endtask

    task automatic idle(input logic rn);
        step(rn, 1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 2'b00, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA500_0000 | i;
        bus.m0_req = 0; bus.m0_wren = 0; bus.m0_addr = '0; bus.m0_write_data = '0;
        bus.m1_req = 0; bus.m1_wren = 0; bus.m1_lock = 0; bus.m1_addr = '0; bus.m1_write_data = '0;

        idle(1'b0);
        idle(1'b0);

        // Plain round robin reads
        step(1'b1, 1'b1, 1'b0, 8'h01, 32'd0, 1'b1, 1'b0, 1'b0, 8'h02, 32'd0, 2'b10, 32'hA500_0001);
        step(1'b1, 1'b1, 1'b0, 8'h01, 32'd0, 1'b1, 1'b0, 1'b0, 8'h02, 32'd0, 2'b01, 32'hA500_0002);
        step(1'b1, 1'b1, 1'b0, 8'h01, 32'd0, 1'b1, 1'b0, 1'b0, 8'h02, 32'd0, 2'b10, 32'hA500_0001);
        step(1'b1, 1'b1, 1'b0, 8'h01, 32'd0, 1'b1, 1'b0, 1'b0, 8'h02, 32'd0, 2'b01, 32'hA500_0002);

        // Locked burst capped at 4, then m0, then m1 re-enters burst
        bothrd(1'b1, 2'b10);
        bothrd(1'b1, 2'b01);
        bothrd(1'b1, 2'b01);
        bothrd(1'b1, 2'b01);
        bothrd(1'b1, 2'b01);
        bothrd(1'b1, 2'b10);
        bothrd(1'b1, 2'b01);

        // Hole fill at bcnt=2 must not advance the count
        bothrd(1'b1, 2'b01);
        step(1'b1, 1'b1, 1'b0, 8'h04, 32'd0, 1'b0, 1'b0, 1'b1, 8'h05, 32'd0, 2'b10, 32'hA500_0004);
        bothrd(1'b1, 2'b01);
        bothrd(1'b1, 2'b01);
        bothrd(1'b1, 2'b10);

        // Lock dropped after two beats: RR resumes favouring m0
        bothrd(1'b1, 2'b01);
        bothrd(1'b1, 2'b01);
        bothrd(1'b0, 2'b10);
        bothrd(1'b0, 2'b01);

        // Same-address write collision, then readbacks
        step(1'b1, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 8'h10, 32'h1234_5678, 2'b10, 32'd0);
        step(1'b1, 1'b1, 1'b0, 8'h10, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 2'b10, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b1, 1'b0, 8'h10, 32'h1234_5678, 2'b01, 32'd0);
        step(1'b1, 1'b1, 1'b0, 8'h10, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 2'b10, 32'h1234_5678);

        // No grant leaves prio at m1
        idle(1'b1);
        bothrd(1'b0, 2'b01);

        // Read granted right before reset is dropped; reset restores m0 priority
        step(1'b1, 1'b1, 1'b0, 8'h07, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 2'b10, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h07, 32'd0, 1'b1, 1'b1, 1'b1, 8'h06, 32'd0, 2'b00, 32'd0);
        step(1'b1, 1'b1, 1'b0, 8'h07, 32'd0, 1'b1, 1'b0, 1'b0, 8'h06, 32'd0, 2'b10, 32'hA500_0007);

        idle(1'b1);
        idle(1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drain", gq.size() + r0q.size() + r1q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
